// File: rtl/dacc_bi.sv
// Bipolar stochastic-to-binary accumulator: sequences one operand-load / RNG-clear /
// count window over NUM_IN product bitstreams and reports 2*ones - NUM_IN*2^CNTWD.
`timescale 1ns/1ps
module dacc_bi #(
  parameter  int NUM_IN = 16,
  parameter  int CNTWD  = 8,
  localparam int ACCWD  = CNTWD + $clog2(NUM_IN) + 1,
  localparam int OUTWD  = ACCWD + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NUM_IN-1:0]       iBits,
  output logic                    oLoad,
  output logic                    oRngClr,
  output logic                    oRngEn,
  output logic                    busy,
  output logic signed [OUTWD-1:0] oSum,
  output logic                    oValid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Bipolar zero point: every bit of every stream counted as one.
  localparam logic [OUTWD-1:0] FULL = OUTWD'(NUM_IN) << CNTWD;

  logic [1:0]       state_q, state_d;
  logic [CNTWD-1:0] cnt_q, cnt_d;
  logic [ACCWD-1:0] acc_q, acc_d;
  logic [OUTWD-1:0] sum_q, sum_d;
  logic [ACCWD-1:0] pop;
  logic [ACCWD-1:0] acc_sum;
  logic             last;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      pop = pop + ACCWD'(iBits[i]);
    end
  end

  assign acc_sum = acc_q + pop;
  assign last    = &cnt_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        cnt_d   = '0;
        acc_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          // Doubling is a shift into OUTWD bits; the modular subtract yields the signed result.
          sum_d   = {acc_sum, 1'b0} - FULL;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = start ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
    end
  end

  assign oLoad   = (state_q == S_LOAD);
  assign oRngClr = (state_q == S_LOAD);
  assign oRngEn  = (state_q == S_RUN);
  assign busy    = (state_q == S_LOAD) || (state_q == S_RUN);
  assign oValid  = (state_q == S_DONE);
  assign oSum    = $signed(sum_q);

endmodule

// File: tb/tb_dacc_bi.sv
// Directed bench for dacc_bi at default parameters (16 streams, 256-cycle window).
`timescale 1ns/1ps
module tb_dacc_bi;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [15:0]        iBits;
  logic               oLoad, oRngClr, oRngEn, busy, oValid;
  logic signed [13:0] oSum;

  int vectors     = 0;
  int miscompares = 0;

  dacc_bi #(.NUM_IN(16), .CNTWD(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .iBits   (iBits),
    .oLoad   (oLoad),
    .oRngClr (oRngClr),
    .oRngEn  (oRngEn),
    .busy    (busy),
    .oSum    (oSum),
    .oValid  (oValid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Samples land 1 ns after the rising edge; inputs change at that point too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".oLoad"},   32'(oLoad),   0);
    check({tag, ".oRngClr"}, 32'(oRngClr), 0);
    check({tag, ".oRngEn"},  32'(oRngEn),  0);
    check({tag, ".busy"},    32'(busy),    0);
    check({tag, ".oValid"},  32'(oValid),  0);
  endtask

  // One window started by a single start pulse; iBits alternates a/b each cycle.
  // Latency counts the start-sampling edge as cycle 1, so oValid appears at cycle 258.
  task automatic run_window(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input int inject_at, input int exp_sum);
    int lat = 0;
    int busy_n = 0;
    bit ph = 1'b0;
    iBits = a;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    if (busy) busy_n++;
    check({tag, ".load_oLoad"},   32'(oLoad),   1);
    check({tag, ".load_oRngClr"}, 32'(oRngClr), 1);
    check({tag, ".load_oRngEn"},  32'(oRngEn),  0);
    while (!oValid && lat < 400) begin
      ph = ~ph;
      iBits = ph ? b : a;
      start = (lat == inject_at);
      step();
      lat++;
      if (busy) busy_n++;
      if (lat == 2) begin
        check({tag, ".run_oRngEn"}, 32'(oRngEn), 1);
        check({tag, ".run_oLoad"},  32'(oLoad),  0);
      end
    end
    start = 1'b0;
    check({tag, ".valid_seen"}, 32'(oValid), 1);
    check({tag, ".latency"},    lat,         258);
    check({tag, ".busy_cycles"}, busy_n,     257);
    check({tag, ".oSum"},       32'(oSum),   exp_sum);
    step();
    check({tag, ".valid_drop"}, 32'(oValid), 0);
    check({tag, ".post_busy"},  32'(busy),   0);
    check({tag, ".oSum_hold"},  32'(oSum),   exp_sum);
  endtask

  initial begin
    int nv, t, loads, clrs, prev_t, extra_valid, extra_busy;

    rst_n = 1'b0;
    start = 1'b0;
    iBits = '0;
    step();
    step();
    check_idle_outputs("reset");
    check("reset.oSum", 32'(oSum), 0);
    #2 rst_n = 1'b1;
    step();
    check_idle_outputs("idle");

    run_window("ones",   16'hFFFF, 16'hFFFF, 0,  4096);
    run_window("zeros",  16'h0000, 16'h0000, 0, -4096);
    run_window("one_bit",16'h0001, 16'h0001, 0, -3584);
    run_window("alt",    16'hFFFF, 16'h0000, 0,  0);
    run_window("half",   16'h00FF, 16'h00FF, 0,  0);

    // start raised mid-RUN is dropped: no second window follows.
    run_window("inject", 16'h0001, 16'h0001, 100, -3584);
    extra_valid = 0;
    extra_busy  = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (oValid) extra_valid++;
      if (busy)   extra_busy++;
    end
    check("inject.extra_valid", extra_valid, 0);
    check("inject.extra_busy",  extra_busy,  0);

    // Three back-to-back windows with start held high.
    iBits  = 16'hFFFF;
    start  = 1'b1;
    nv     = 0;
    t      = 0;
    loads  = 0;
    clrs   = 0;
    prev_t = 0;
    while (nv < 3 && t < 1000) begin
      step();
      t++;
      if (oLoad)   loads++;
      if (oRngClr) clrs++;
      if (oValid) begin
        nv++;
        check($sformatf("b2b.w%0d.spacing", nv), t - prev_t, 258);
        check($sformatf("b2b.w%0d.oSum", nv), 32'(oSum), 4096);
        prev_t = t;
        if (nv == 3) start = 1'b0;
      end
    end
    check("b2b.windows", nv,    3);
    check("b2b.loads",   loads, 3);
    check("b2b.clrs",    clrs,  3);
    step();
    check("b2b.idle_busy", 32'(busy), 0);
    check("b2b.idle_load", 32'(oLoad), 0);

    // Asynchronous reset at RUN cycle 128 clears everything, including oSum.
    iBits = 16'hFFFF;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 128; i++) step();
    check("midrun.oRngEn_before", 32'(oRngEn), 1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("midrun_rst");
    check("midrun_rst.oSum", 32'(oSum), 0);
    #2 rst_n = 1'b1;
    extra_valid = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (oValid || busy) extra_valid++;
    end
    check("midrun.no_resume", extra_valid, 0);
    run_window("after_rst", 16'hFFFF, 16'hFFFF, 0, 4096);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
